sgpr_secded: RTL

SECDED-protected general-purpose register file for the fault-tolerant core: 31 (or 15 with RV32E) registers of DATA_WIDTH bits, with R0 hard-wired to zero. Every stored word carries Hamming check bits plus an overall parity bit, and both read ports return corrected data with per-port error flags. A background scrubber walks the file, writes back single-bit corrections and reports uncorrectable words. A fault-injection port lets the bench and on-chip test logic corrupt stored bits on purpose.

---
 rtl/sgpr_secded_if.sv | 26 ++
 rtl/sgpr_secded.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sgpr_secded_if.sv
// Register-file access bundle: two combinational read ports and one write port.
interface sgpr_secded_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [4:0]            raddr_a_i;
  logic [4:0]            raddr_b_i;
  logic [DATA_WIDTH-1:0] rdata_a_o;
  logic [DATA_WIDTH-1:0] rdata_b_o;
  logic                  rcorr_a_o;
  logic                  rcorr_b_o;
  logic                  runcorr_a_o;
  logic                  runcorr_b_o;
  logic [4:0]            waddr_a_i;
  logic [DATA_WIDTH-1:0] wdata_a_i;
  logic                  we_a_i;

  modport master (
    output raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i, we_a_i,
    input  rdata_a_o, rdata_b_o, rcorr_a_o, rcorr_b_o, runcorr_a_o, runcorr_b_o
  );

  modport slave (
    input  raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i, we_a_i,
    output rdata_a_o, rdata_b_o, rcorr_a_o, rcorr_b_o, runcorr_a_o, runcorr_b_o
  );
endinterface

// File: rtl/sgpr_secded.sv
// SECDED-protected GPR file (R0 hard-wired to zero) with background scrubber
// and a fault-injection port.
module sgpr_secded #(
  parameter bit          RV32E          = 1'b0,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SCRUB_INTERVAL = 64,
  parameter int unsigned CNT_WIDTH      = 16,
  localparam int unsigned P  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1),
  localparam int unsigned CW = DATA_WIDTH + P + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 test_en_i,
  sgpr_secded_if.slave         rf,
  input  logic                 scrub_en_i,
  input  logic                 inj_en_i,
  input  logic [4:0]           inj_addr_i,
  input  logic [CW-1:0]        inj_mask_i,
  input  logic                 cnt_clr_i,
  output logic [CNT_WIDTH-1:0] corr_cnt_o,
  output logic [CNT_WIDTH-1:0] uncorr_cnt_o,
  output logic                 uncorr_o,
  output logic [4:0]           uncorr_addr_o,
  output logic                 scrub_busy_o
);
  localparam int unsigned AW = RV32E ? 4 : 5;
  localparam int unsigned NW = 1 << AW;
  localparam int unsigned IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, FIX} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CW-1:0]         cw;
    logic                  corr;
    logic                  uncorr;
  } dec_t;

  function automatic logic [CW-1:0] enc(input logic [DATA_WIDTH-1:0] d);
    logic [CW-1:0] cw;
    int unsigned   k;
    cw = '0;
    k  = 0;
    for (int unsigned pos = 1; pos < CW; pos++)
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    for (int unsigned i = 0; i < P; i++)
      for (int unsigned pos = 1; pos < CW; pos++)
        if (pos[i] && ((pos & (pos - 1)) != 0)) cw[1 << i] = cw[1 << i] ^ cw[pos];
    cw[0] = ^cw[CW-1:1];
    return cw;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [CW-1:0] cw);
    logic [DATA_WIDTH-1:0] d;
    int unsigned           k;
    d = '0;
    k = 0;
    for (int unsigned pos = 1; pos < CW; pos++)
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos];
        k++;
      end
    return d;
  endfunction

  // Syndrome 0 with a parity mismatch means the overall parity bit itself flipped.
  function automatic dec_t decode(input logic [CW-1:0] cw);
    dec_t       r;
    logic [P-1:0] s;
    logic       pe;
    logic [CW-1:0] fixed;
    s = '0;
    for (int unsigned pos = 1; pos < CW; pos++)
      for (int unsigned i = 0; i < P; i++)
        if (pos[i]) s[i] = s[i] ^ cw[pos];
    pe    = ^cw;
    fixed = cw;
    if (pe)
      for (int unsigned pos = 0; pos < CW; pos++)
        if (pos == 32'(s)) fixed[pos] = ~fixed[pos];
    r.cw     = fixed;
    r.corr   = pe;
    r.uncorr = !pe && (s != '0);
    r.data   = extract(r.uncorr ? cw : fixed);
    return r;
  endfunction

  logic [CW-1:0] mem [NW];
  logic [AW-1:0] ra, rb, wa, ia, scrub_addr;
  dec_t          dec_a, dec_b, sdec;
  logic [CW-1:0] wr_cw, fix_cw;
  logic [IW-1:0] ival_q;
  state_t        state_q, state_d;
  logic          load_ival, dec_ival, advance, latch_fix, fix_we, inc_corr, inc_uncorr;
  logic          wr_hit, inj_hit;
  logic          unused_bits;

  assign unused_bits = ^{test_en_i, rf.raddr_a_i, rf.raddr_b_i, rf.waddr_a_i, inj_addr_i};

  assign ra    = rf.raddr_a_i[AW-1:0];
  assign rb    = rf.raddr_b_i[AW-1:0];
  assign wa    = rf.waddr_a_i[AW-1:0];
  assign ia    = inj_addr_i[AW-1:0];
  assign wr_cw = enc(rf.wdata_a_i);
  assign sdec  = decode(mem[scrub_addr]);

  always_comb begin
    dec_a          = decode(mem[ra]);
    dec_b          = decode(mem[rb]);
    rf.rdata_a_o   = dec_a.data;
    rf.rcorr_a_o   = dec_a.corr;
    rf.runcorr_a_o = dec_a.uncorr;
    rf.rdata_b_o   = dec_b.data;
    rf.rcorr_b_o   = dec_b.corr;
    rf.runcorr_b_o = dec_b.uncorr;
    if (ra == '0) begin
      rf.rdata_a_o   = '0;
      rf.rcorr_a_o   = 1'b0;
      rf.runcorr_a_o = 1'b0;
    end
    if (rb == '0) begin
      rf.rdata_b_o   = '0;
      rf.rcorr_b_o   = 1'b0;
      rf.runcorr_b_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NW; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NW; i++) begin
        if (rf.we_a_i && wa == AW'(i))
          mem[i] <= wr_cw ^ ((inj_en_i && ia == AW'(i)) ? inj_mask_i : '0);
        else if (inj_en_i && ia == AW'(i))
          mem[i] <= mem[i] ^ inj_mask_i;
        else if (fix_we && scrub_addr == AW'(i))
          mem[i] <= fix_cw;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign wr_hit  = rf.we_a_i && (wa == scrub_addr);
  assign inj_hit = inj_en_i && (ia == scrub_addr);

  always_comb begin
    state_d      = state_q;
    load_ival    = 1'b0;
    dec_ival     = 1'b0;
    advance      = 1'b0;
    latch_fix    = 1'b0;
    fix_we       = 1'b0;
    inc_corr     = 1'b0;
    inc_uncorr   = 1'b0;
    scrub_busy_o = 1'b0;
    unique case (state_q)
      IDLE: if (scrub_en_i) begin
        state_d   = WAIT;
        load_ival = 1'b1;
      end
      WAIT: begin
        if (!scrub_en_i)        state_d = IDLE;
        else if (ival_q == '0)  state_d = CHECK;
        else                    dec_ival = 1'b1;
      end
      CHECK: begin
        scrub_busy_o = 1'b1;
        if (sdec.uncorr) begin
          inc_uncorr = 1'b1;
          advance    = 1'b1;
          load_ival  = 1'b1;
          state_d    = WAIT;
        end else if (sdec.corr) begin
          inc_corr  = 1'b1;
          latch_fix = 1'b1;
          state_d   = FIX;
        end else begin
          advance   = 1'b1;
          load_ival = 1'b1;
          state_d   = WAIT;
        end
      end
      FIX: begin
        scrub_busy_o = 1'b1;
        fix_we       = !wr_hit && !inj_hit;
        advance      = 1'b1;
        load_ival    = 1'b1;
        state_d      = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ival_q        <= '0;
      scrub_addr    <= AW'(1);
      fix_cw        <= '0;
      corr_cnt_o    <= '0;
      uncorr_cnt_o  <= '0;
      uncorr_o      <= 1'b0;
      uncorr_addr_o <= '0;
    end else begin
      if (load_ival)     ival_q <= IW'(SCRUB_INTERVAL - 1);
      else if (dec_ival) ival_q <= ival_q - 1'b1;
      if (advance)       scrub_addr <= (&scrub_addr) ? AW'(1) : scrub_addr + 1'b1;
      if (latch_fix)     fix_cw <= sdec.cw;
      if (cnt_clr_i) begin
        corr_cnt_o   <= '0;
        uncorr_cnt_o <= '0;
      end else begin
        if (inc_corr && !(&corr_cnt_o))     corr_cnt_o   <= corr_cnt_o + 1'b1;
        if (inc_uncorr && !(&uncorr_cnt_o)) uncorr_cnt_o <= uncorr_cnt_o + 1'b1;
      end
      uncorr_o <= inc_uncorr;
      if (inc_uncorr) uncorr_addr_o <= 5'(scrub_addr);
    end
  end
endmodule
